hex_debug_monitor: RTL and testbench

HEX_DEBUG_MONITOR -- requirements
Module: hex_debug_monitor

---
 rtl/debug_pkg.sv | 14 +
 rtl/dbg_snapshot_bank.sv | 41 ++++
 rtl/hex_debug_monitor.sv | 115 +++++++++++
 tb/tb_hex_debug_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared mode encoding and display constants for the hex debug monitor
package debug_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'b00,
    MODE_SNAP   = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_FREEZE = 2'b11
  } dbg_mode_t;

  // Value shown in every digit when the selected channel does not exist.
  localparam logic [3:0] DIGIT_FILL = 4'h1;

endpackage

// File: rtl/dbg_snapshot_bank.sv
// rtl/dbg_snapshot_bank.sv - per-channel snapshot registers and sticky capture flags
module dbg_snapshot_bank #(
  parameter int NUM_CH = 8,
  parameter int WORD_W = 24,
  parameter int SEL_W  = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_CH*WORD_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_strobe,
  input  logic                     snap_mode,
  input  logic [SEL_W-1:0]         cur_ch,
  output logic [NUM_CH*WORD_W-1:0] snap_data,
  output logic [NUM_CH-1:0]        capture_flag
);

  logic [NUM_CH-1:0] clear_mask;

  // A flag is acknowledged only once its channel has been on display in SNAP mode.
  always_comb begin
    clear_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clear_mask[i] = snap_mode && (cur_ch == SEL_W'(i));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      snap_data    <= '0;
      capture_flag <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_strobe[i]) begin
          snap_data[i*WORD_W +: WORD_W] <= ch_data[i*WORD_W +: WORD_W];
        end
      end
      capture_flag <= ch_strobe | (capture_flag & ~clear_mask);
    end
  end

endmodule

// File: rtl/hex_debug_monitor.sv
// rtl/hex_debug_monitor.sv - multi-channel hex display source with live, snapshot, auto-cycle and freeze modes
module hex_debug_monitor
  import debug_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int DIGITS    = 6,
  parameter int CYCLE_DIV = 25_000_000,
  localparam int SEL_W    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  localparam int WORD_W   = DIGITS * 4,
  localparam int CNT_W    = $clog2(CYCLE_DIV)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_CH*WORD_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_strobe,
  input  logic [SEL_W-1:0]         sel,
  input  logic [1:0]               mode,
  output logic [WORD_W-1:0]        hex_digits,
  output logic [SEL_W-1:0]         cur_ch,
  output logic [NUM_CH-1:0]        capture_flag
);

  dbg_mode_t                cur_mode;
  dbg_mode_t                prev_mode;
  logic                     post_reset;
  logic [CNT_W-1:0]         step;
  logic                     step_done;
  logic                     auto_entry;
  logic [SEL_W-1:0]         next_ch;
  logic [NUM_CH*WORD_W-1:0] snap_data;
  logic [WORD_W-1:0]        sel_word;
  logic [WORD_W-1:0]        sel_snap;
  logic [WORD_W-1:0]        auto_word;
  logic                     sel_hit;
  logic                     auto_hit;

  assign cur_mode  = dbg_mode_t'(mode);
  assign step_done = (step == CNT_W'(CYCLE_DIV - 1));
  // The first cycle after reset is a continuation of AUTO at channel 0, not an entry.
  assign auto_entry = (cur_mode == MODE_AUTO) && (prev_mode != MODE_AUTO) && !post_reset;

  always_comb begin
    next_ch = cur_ch;
    if (auto_entry) begin
      next_ch = sel;
    end else if (step_done) begin
      next_ch = (cur_ch >= SEL_W'(NUM_CH - 1)) ? '0 : cur_ch + SEL_W'(1);
    end
  end

  always_comb begin
    sel_word  = '0;
    sel_snap  = '0;
    auto_word = '0;
    sel_hit   = 1'b0;
    auto_hit  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_hit  = 1'b1;
        sel_word = ch_data[i*WORD_W +: WORD_W];
        sel_snap = snap_data[i*WORD_W +: WORD_W];
      end
      if (next_ch == SEL_W'(i)) begin
        auto_hit  = 1'b1;
        auto_word = ch_data[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_digits <= '0;
      cur_ch     <= '0;
      step       <= '0;
      prev_mode  <= MODE_LIVE;
      post_reset <= 1'b1;
    end else begin
      prev_mode  <= cur_mode;
      post_reset <= 1'b0;
      step       <= '0;
      case (cur_mode)
        MODE_LIVE: begin
          hex_digits <= sel_hit ? sel_word : {DIGITS{DIGIT_FILL}};
          cur_ch     <= sel;
        end
        MODE_SNAP: begin
          hex_digits <= sel_hit ? sel_snap : {DIGITS{DIGIT_FILL}};
          cur_ch     <= sel;
        end
        MODE_AUTO: begin
          hex_digits <= auto_hit ? auto_word : {DIGITS{DIGIT_FILL}};
          cur_ch     <= next_ch;
          step       <= (auto_entry || step_done) ? '0 : step + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  dbg_snapshot_bank #(
    .NUM_CH (NUM_CH),
    .WORD_W (WORD_W),
    .SEL_W  (SEL_W)
  ) u_snapshot_bank (
    .Clk          (Clk),
    .Reset        (Reset),
    .ch_data      (ch_data),
    .ch_strobe    (ch_strobe),
    .snap_mode    (cur_mode == MODE_SNAP),
    .cur_ch       (cur_ch),
    .snap_data    (snap_data),
    .capture_flag (capture_flag)
  );

endmodule

// File: tb/tb_hex_debug_monitor.sv
// tb/tb_hex_debug_monitor.sv - randomized and directed self-checking bench for hex_debug_monitor
module tb_hex_debug_monitor;

  localparam int NCH = 4;
  localparam int DIG = 6;
  localparam int CDIV = 4;
  localparam int WW = DIG * 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [NCH*WW-1:0] ch_data;
  logic [NCH-1:0]   ch_strobe;
  logic [1:0]       sel;
  logic [1:0]       mode;
  logic [WW-1:0]    hex_digits;
  logic [1:0]       cur_ch;
  logic [NCH-1:0]   capture_flag;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  hex_debug_monitor #(.NUM_CH(NCH), .DIGITS(DIG), .CYCLE_DIV(CDIV)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ch_data      (ch_data),
    .ch_strobe    (ch_strobe),
    .sel          (sel),
    .mode         (mode),
    .hex_digits   (hex_digits),
    .cur_ch       (cur_ch),
    .capture_flag (capture_flag)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: AUTO position is derived from elapsed cycles since entry.
  logic [WW-1:0] m_snap [NCH];
  logic [NCH-1:0] m_flag;
  logic [WW-1:0] m_hex;
  int m_cur, m_prev, m_start, m_n;
  bit m_jr, m_valid = 1'b0;

  always @(posedge Clk) begin
    int old_cur;
    if (Reset) begin
      for (int i = 0; i < NCH; i++) m_snap[i] = '0;
      m_flag = '0; m_hex = '0; m_cur = 0; m_prev = 0;
      m_start = 0; m_n = 0; m_jr = 1'b1; m_valid = 1'b1;
    end else if (m_valid) begin
      old_cur = m_cur;
      case (mode)
        2'd0: begin m_cur = sel; m_hex = ch_data[sel*WW +: WW]; end
        2'd1: begin m_cur = sel; m_hex = m_snap[sel]; end
        2'd2: begin
          if (m_prev != 2 && !m_jr) begin m_start = sel; m_n = 0; end
          else m_n++;
          m_cur = (m_start + m_n / CDIV) % NCH;
          m_hex = ch_data[m_cur*WW +: WW];
        end
        default: ;
      endcase
      for (int i = 0; i < NCH; i++) begin
        m_flag[i] = ch_strobe[i] | (m_flag[i] & !(mode == 2'd1 && old_cur == i));
        if (ch_strobe[i]) m_snap[i] = ch_data[i*WW +: WW];
      end
      m_prev = mode;
      m_jr = 1'b0;
    end
    #1;
    if (m_valid && chk_en) begin
      check("model_hex", 32'(hex_digits), 32'(m_hex));
      check("model_cur", 32'(cur_ch), 32'(m_cur));
      check("model_flag", 32'(capture_flag), 32'(m_flag));
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic set_ch(input int i, input logic [WW-1:0] w);
    ch_data[i*WW +: WW] = w;
  endtask

  logic [1:0] exp_seq [16] = '{3,3,3,3,0,0,0,0,1,1,1,1,2,2,2,2};

  initial begin
    Reset = 1'b1; ch_data = '0; ch_strobe = '0; sel = '0; mode = 2'd0;
    cyc(); cyc();
    chk_en = 1'b1;
    check("reset_hex", 32'(hex_digits), 32'h0);
    check("reset_cur", 32'(cur_ch), 32'h0);
    check("reset_flag", 32'(capture_flag), 32'h0);
    Reset = 1'b0;

    // LIVE view of channel 2
    mode = 2'd0; sel = 2'd2; set_ch(2, 24'hABCDEF);
    cyc();
    check("live_hex", 32'(hex_digits), 32'hABCDEF);
    check("live_cur", 32'(cur_ch), 32'h2);

    // SNAP keeps captured value even when live data moves on
    set_ch(1, 24'h123456); ch_strobe = 4'b0010;
    cyc();
    ch_strobe = '0; set_ch(1, 24'h999999); mode = 2'd1; sel = 2'd1;
    cyc();
    check("snap_hex", 32'(hex_digits), 32'h123456);
    check("snap_flag_set", 32'(capture_flag[1]), 32'h1);
    cyc();
    check("snap_hex_hold", 32'(hex_digits), 32'h123456);
    check("snap_flag_clr", 32'(capture_flag[1]), 32'h0);

    // AUTO entered from sel=3, wraps through 0,1,2 and back to 3
    mode = 2'd2; sel = 2'd3;
    for (int k = 0; k < 16; k++) begin
      cyc();
      check("auto_seq", 32'(cur_ch), 32'(exp_seq[k]));
    end
    cyc();
    check("auto_wrap", 32'(cur_ch), 32'h3);

    // FREEZE holds display while capture continues
    mode = 2'd0; sel = 2'd0; set_ch(0, 24'h00BEEF);
    cyc();
    check("frz_pre", 32'(hex_digits), 32'h00BEEF);
    mode = 2'd3; set_ch(0, 24'hC0FFEE); ch_strobe = 4'b0001;
    cyc();
    ch_strobe = '0;
    cyc();
    check("frz_hold", 32'(hex_digits), 32'h00BEEF);
    check("frz_cur", 32'(cur_ch), 32'h0);
    mode = 2'd1; sel = 2'd0;
    cyc();
    check("frz_snap", 32'(hex_digits), 32'hC0FFEE);

    // Same-cycle strobe on the displayed SNAP channel
    mode = 2'd0; set_ch(2, 24'h222222); ch_strobe = 4'b0100;
    cyc();
    ch_strobe = '0; mode = 2'd1; sel = 2'd2;
    cyc();
    cyc();
    check("same_pre", 32'(hex_digits), 32'h222222);
    check("same_pre_flag", 32'(capture_flag[2]), 32'h0);
    set_ch(2, 24'h333333); ch_strobe = 4'b0100;
    cyc();
    ch_strobe = '0;
    check("same_old", 32'(hex_digits), 32'h222222);
    check("same_flag", 32'(capture_flag[2]), 32'h1);
    cyc();
    check("same_new", 32'(hex_digits), 32'h333333);

    // Reset mid-AUTO at channel 2, then restart at channel 0 with full period
    mode = 2'd0; cyc();
    mode = 2'd2; sel = 2'd1;
    cyc(); cyc(); cyc(); cyc(); cyc();
    check("rst_pre_cur", 32'(cur_ch), 32'h2);
    Reset = 1'b1; ch_strobe = 4'b1111;
    cyc();
    check("rst_hex", 32'(hex_digits), 32'h0);
    check("rst_cur", 32'(cur_ch), 32'h0);
    check("rst_flag", 32'(capture_flag), 32'h0);
    Reset = 1'b0; ch_strobe = '0; sel = 2'd3; set_ch(0, 24'h0A0A0A);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("rst_auto_ch0", 32'(cur_ch), 32'h0);
    end
    check("rst_auto_hex", 32'(hex_digits), 32'h0A0A0A);
    cyc();
    check("rst_auto_ch1", 32'(cur_ch), 32'h1);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      Reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
      sel = 2'($urandom_range(0, 3));
      ch_strobe = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 1) == 1) set_ch(i, 24'($urandom));
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
